// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline for a 5-stage MIPS-style core: carries ID control through
// EX, MEM and WB, detects load-use hazards, resolves taken branches and counts retirements.
module ctrl_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  id_wb,
  input  logic [2:0]  id_m,
  input  logic [3:0]  id_ex,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_valid,
  input  logic        mem_zero,
  output logic        ex_regdst,
  output logic [1:0]  ex_aluop,
  output logic        ex_alusrc,
  output logic        ex_valid,
  output logic        mem_branch,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic        mem_valid,
  output logic        wb_regwrite,
  output logic        wb_memtoreg,
  output logic        wb_valid,
  output logic        stall,
  output logic        pcsrc,
  output logic [15:0] retire_cnt
);

  logic        r_vld_p0;
  logic [3:0]  r_ex_p0;
  logic [2:0]  r_m_p0;
  logic [1:0]  r_wb_p0;
  logic [4:0]  r_rt_p0;

  logic        r_vld_p1;
  logic [2:0]  r_m_p1;
  logic [1:0]  r_wb_p1;

  logic        r_vld_p2;
  logic [1:0]  r_wb_p2;

  logic [15:0] r_retire_cnt;

  logic        w_rt_hit;
  logic        w_stall;
  logic        w_pcsrc;
  logic        w_load_p0;

  // Load-use hazard: a load in EX whose destination feeds the ID instruction.
  assign w_rt_hit  = (r_rt_p0 != 5'd0) && ((r_rt_p0 == id_rs) || (r_rt_p0 == id_rt));
  assign w_stall   = id_valid & r_vld_p0 & r_m_p0[1] & w_rt_hit;
  assign w_pcsrc   = r_vld_p1 & r_m_p1[2] & mem_zero;
  // Only a real, unsquashed instruction is captured; anything else becomes an all-zero bubble.
  assign w_load_p0 = id_valid & ~w_stall & ~w_pcsrc;

  // ID -> EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p0 <= 1'b0;
      r_ex_p0  <= 4'd0;
      r_m_p0   <= 3'd0;
      r_wb_p0  <= 2'd0;
      r_rt_p0  <= 5'd0;
    end else if (w_load_p0) begin
      r_vld_p0 <= 1'b1;
      r_ex_p0  <= id_ex;
      r_m_p0   <= id_m;
      r_wb_p0  <= id_wb;
      r_rt_p0  <= id_rt;
    end else begin
      r_vld_p0 <= 1'b0;
      r_ex_p0  <= 4'd0;
      r_m_p0   <= 3'd0;
      r_wb_p0  <= 2'd0;
      r_rt_p0  <= 5'd0;
    end
  end

  // EX -> MEM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_m_p1   <= 3'd0;
      r_wb_p1  <= 2'd0;
    end else if (w_pcsrc) begin
      r_vld_p1 <= 1'b0;
      r_m_p1   <= 3'd0;
      r_wb_p1  <= 2'd0;
    end else begin
      r_vld_p1 <= r_vld_p0;
      r_m_p1   <= r_m_p0;
      r_wb_p1  <= r_wb_p0;
    end
  end

  // MEM -> WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2 <= 1'b0;
      r_wb_p2  <= 2'd0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      r_wb_p2  <= r_wb_p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= 16'd0;
    end else if (r_vld_p2) begin
      r_retire_cnt <= r_retire_cnt + 16'd1;
    end
  end

  assign ex_regdst    = r_ex_p0[3];
  assign ex_aluop     = r_ex_p0[2:1];
  assign ex_alusrc    = r_ex_p0[0];
  assign ex_valid     = r_vld_p0;
  assign mem_branch   = r_m_p1[2];
  assign mem_memread  = r_m_p1[1];
  assign mem_memwrite = r_m_p1[0];
  assign mem_valid    = r_vld_p1;
  assign wb_regwrite  = r_wb_p2[1];
  assign wb_memtoreg  = r_wb_p2[0];
  assign wb_valid     = r_vld_p2;
  assign stall        = w_stall;
  assign pcsrc        = w_pcsrc;
  assign retire_cnt   = r_retire_cnt;

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port id_wb, input, 2 bits: decode WB bundle {regwrite, memtoreg}.
REQ-004 SHALL have port id_m, input, 3 bits: decode M bundle {branch, memread, memwrite}.
REQ-005 SHALL have port id_ex, input, 4 bits: decode EX bundle {regdst, aluop[1:0], alusrc}.
REQ-006 SHALL have ports id_rs and id_rt, input, 5 bits each: source register fields of the ID-stage instruction.
REQ-007 SHALL have port id_valid, input, 1 bit: ID-stage instruction is real; 0 means bubble.
REQ-008 SHALL have port mem_zero, input, 1 bit: ALU zero flag of the MEM-stage instruction.
REQ-009 SHALL have outputs ex_regdst (1), ex_aluop (2), ex_alusrc (1) and ex_valid (1): the ID/EX stage fields.
REQ-010 SHALL have outputs mem_branch, mem_memread, mem_memwrite and mem_valid (1 each): the EX/MEM stage fields.
REQ-011 SHALL have outputs wb_regwrite, wb_memtoreg and wb_valid (1 each): the MEM/WB stage fields.
REQ-012 SHALL have outputs stall (1): hold PC and IF/ID, and pcsrc (1): branch taken, redirect PC.
REQ-013 SHALL have output retire_cnt, 16 bits: count of instructions leaving WB.

Function
REQ-014 SHALL hold three stage registers (ID/EX, EX/MEM, MEM/WB), each carrying a valid bit plus the remaining control bundles; ID/EX SHALL also hold ex_rt (5 bits).
REQ-015 SHALL define a bubble as valid=0 with every control bit 0.
REQ-016 SHALL load a bubble into ID/EX when id_valid=0; x bits on id_* SHALL never reach outputs while the matching valid bit is 0.
REQ-017 SHALL combinationally drive stall=1 iff id_valid & ex_valid & ID/EX memread & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt).
REQ-018 SHALL combinationally drive pcsrc=1 iff mem_valid & mem_branch & mem_zero.
REQ-019 On a normal edge (pcsrc=0, stall=0): ID/EX<=ID inputs, EX/MEM<=ID/EX M+WB, MEM/WB<=EX/MEM WB.
REQ-020 On a stall edge (pcsrc=0, stall=1): ID/EX<=bubble, EX/MEM and MEM/WB advance normally (a one-cycle load-use bubble).
REQ-021 On a flush edge (pcsrc=1): ID/EX<=bubble and EX/MEM<=bubble; MEM/WB takes the branch's WB normally; pcsrc SHALL take precedence over stall.
REQ-022 Latency: EX fields SHALL appear 1 cycle after capture, M fields 2 cycles after, WB fields 3 cycles after.
REQ-023 retire_cnt SHALL increment by 1 on every edge where wb_valid=1, wrapping 0xFFFF->0x0000.
REQ-024 Outputs SHALL be driven directly from stage registers (no combinational path from id_* to ex_/mem_/wb_ outputs).

Reset
REQ-025 rst_n=0 SHALL immediately, without a clock, clear all stage registers, valid bits, ex_rt and retire_cnt to 0; stall and pcsrc SHALL be 0.
REQ-026 Reset deasserted mid-operation SHALL restart from an empty pipeline; the first capture SHALL occur on the first rising edge with rst_n=1.

Verification
REQ-027 Reset mid-flight: three valid R-types in the pipe, pull rst_n low between edges -> all outputs 0 at once, retire_cnt=0.
REQ-028 R-type: id_ex=1100, id_m=000, id_wb=10, valid -> edge1 ex_regdst=1, ex_aluop=10, ex_alusrc=0; edge2 mem_* =0, mem_valid=1; edge3 wb_regwrite=1, wb_memtoreg=0; edge4 retire_cnt=1.
REQ-029 Load-use: lw (0001/010/11, rt=5) then R-type with rs=5 -> stall=1 for one cycle, ex_valid=0 next cycle, R-type in EX one cycle later, no further stall.
REQ-030 lw with rt=0 followed by an instruction with rs=0 -> stall stays 0.
REQ-031 Taken beq (x010/100/0x) with mem_zero=1 in MEM -> pcsrc=1; next edge ex_valid=0, mem_valid=0, wb_valid=1 with wb_regwrite=0.
REQ-032 stall and pcsrc both 1 on the same edge -> flush behaviour only; with retire_cnt preset by clocking to 0xFFFF, one more retirement -> 0x0000.
